// File: rtl/pointwise_io_pkg.sv
// pointwise_io_pkg: shared types for the pointwise accelerator output path.
// Revision: 1.0
`default_nettype none

package pointwise_io_pkg;

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } collector_state_e;

   typedef struct packed {
      logic              last;
      logic [DATA_W-1:0] data;
   } out_word_t;

   function automatic logic [31:0] rotl1(input logic [31:0] v);
      return {v[30:0], v[31]};
   endfunction

endpackage

`default_nettype wire

// File: rtl/pointwise_sync_fifo.sv
// pointwise_sync_fifo: small synchronous FIFO of out_word_t with synchronous clear.
// Revision: 1.0
`default_nettype none

module pointwise_sync_fifo
   import pointwise_io_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  out_word_t        wr_word,
   input  logic             pop,
   output out_word_t        rd_word,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   out_word_t         mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A full FIFO may still accept a word when the same cycle frees a slot.
   assign do_push = push && (!full || do_pop);
   assign rd_word = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= wr_word;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/pointwise_output_collector.sv
// pointwise_output_collector: buffers the pointwise write stream onto a ready/valid frame stream.
// Optional COLLECTOR_CHECKSUM_EN adds a rotate-xor checksum output. Revision: 1.0
`default_nettype none

module pointwise_output_collector #(
   parameter  int DATA_W       = 16,
   parameter  int FRAME_PIXELS = 4096,
   parameter  int FIFO_DEPTH   = 8,
   localparam int CNT_W        = $clog2(FRAME_PIXELS + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              hw_output_stencil_op_hcompute_hw_output_stencil_write_valid,
   input  logic [DATA_W-1:0] hw_output_stencil_op_hcompute_hw_output_stencil_write [0:0],
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic              m_last,
   output logic              frame_done,
   output logic [CNT_W-1:0]  pixel_count,
   output logic              overflow,
`ifdef COLLECTOR_CHECKSUM_EN
   output logic [31:0]       checksum,
`endif
   output logic              excess
);

   import pointwise_io_pkg::*;

   localparam int FCW = $clog2(FIFO_DEPTH + 1);

   collector_state_e state;
   out_word_t        wr_word;
   out_word_t        rd_word;
   logic             fifo_full;
   logic             fifo_empty;
   logic [FCW-1:0]   fifo_count;
   logic             beat;
   logic             in_frame;
   logic             pop;
   logic             push;
   logic             drop;
   logic             frame_end;
   logic             drained;

   assign beat      = hw_output_stencil_op_hcompute_hw_output_stencil_write_valid;
   assign in_frame  = (state == IDLE) || (state == COLLECT);
   assign pop       = !fifo_empty && m_ready && !flush;
   assign push      = beat && in_frame && (!fifo_full || pop) && !flush;
   assign drop      = beat && in_frame && fifo_full && !pop;
   assign frame_end = beat && in_frame && (pixel_count == CNT_W'(FRAME_PIXELS - 1));
   // No pushes happen in DRAIN, so only the pending pop can empty the FIFO.
   assign drained   = (fifo_count == '0) || ((fifo_count == FCW'(1)) && pop);

   assign wr_word.last = frame_end;
   assign wr_word.data = hw_output_stencil_op_hcompute_hw_output_stencil_write[0];

   assign m_valid = !fifo_empty;
   assign m_data  = fifo_empty ? '0 : rd_word.data;
   assign m_last  = !fifo_empty && rd_word.last;

   pointwise_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (FCW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (flush),
      .push    (push),
      .wr_word (wr_word),
      .pop     (pop),
      .rd_word (rd_word),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pixel_count <= '0;
         overflow    <= 1'b0;
         excess      <= 1'b0;
         frame_done  <= 1'b0;
      end else if (flush) begin
         state       <= IDLE;
         pixel_count <= '0;
         overflow    <= 1'b0;
         excess      <= 1'b0;
         frame_done  <= 1'b0;
      end else begin
         if (beat && in_frame && (pixel_count < CNT_W'(FRAME_PIXELS))) begin
            pixel_count <= pixel_count + CNT_W'(1);
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         if (beat && !in_frame) begin
            excess <= 1'b1;
         end
         unique case (state)
            IDLE: begin
               if (beat) begin
                  state <= frame_end ? DRAIN : COLLECT;
               end
            end
            COLLECT: begin
               if (frame_end) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (drained) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
               end
            end
            DONE: begin
               frame_done <= 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef COLLECTOR_CHECKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         checksum <= '0;
      end else if (flush) begin
         checksum <= '0;
      end else if (push) begin
         checksum <= rotl1(checksum) ^ 32'(wr_word.data);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_pointwise_output_collector.sv
// tb_pointwise_output_collector: directed vector table plus hand-written corner sequences.
// Revision: 1.0
`default_nettype none

module tb_pointwise_output_collector;

   localparam int FP = 16;
   localparam int FD = 8;
   localparam int DW = 16;
   localparam int CW = $clog2(FP + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          wv = 1'b0;
   logic [DW-1:0] wdata [0:0];
   logic          m_ready = 1'b0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_last;
   logic          frame_done;
   logic [CW-1:0] pixel_count;
   logic          overflow;
   logic          excess;
`ifdef COLLECTOR_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   pointwise_output_collector #(
      .DATA_W       (DW),
      .FRAME_PIXELS (FP),
      .FIFO_DEPTH   (FD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .hw_output_stencil_op_hcompute_hw_output_stencil_write_valid (wv),
      .hw_output_stencil_op_hcompute_hw_output_stencil_write       (wdata),
      .m_valid     (m_valid),
      .m_ready     (m_ready),
      .m_data      (m_data),
      .m_last      (m_last),
      .frame_done  (frame_done),
      .pixel_count (pixel_count),
      .overflow    (overflow),
`ifdef COLLECTOR_CHECKSUM_EN
      .checksum    (checksum),
`endif
      .excess      (excess)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wv;
      logic [DW-1:0] data;
      logic          rdy;
      logic          ev;
      logic [DW-1:0] ed;
      logic          el;
      int            epc;
      logic          eovf;
      logic          eexc;
      logic          edone;
   } vec_t;

   vec_t tbl [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input logic v, input int d, input logic rdy, input logic fl);
      wv       = v;
      wdata[0] = DW'(d);
      m_ready  = rdy;
      flush    = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic drain_chk(input int first, input int n);
      for (int k = 0; k < n; k++) begin
         chk($sformatf("drain%0d m_valid", k), 32'(m_valid), 32'd1);
         chk($sformatf("drain%0d m_data", k), 32'(m_data), 32'(first + k));
         step(1'b0, 0, 1'b1, 1'b0);
      end
      chk("drain end m_valid", 32'(m_valid), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      for (int i = 0; i < 20; i++) begin
         tbl[i].wv    = (i != 16);
         tbl[i].data  = (i < 16) ? DW'(i) : DW'(16'h00AA);
         tbl[i].rdy   = 1'b1;
         tbl[i].ev    = (i < 16);
         tbl[i].ed    = (i < 16) ? DW'(i) : '0;
         tbl[i].el    = (i == 15);
         tbl[i].epc   = (i < 16) ? i + 1 : FP;
         tbl[i].eovf  = 1'b0;
         tbl[i].eexc  = (i >= 17);
         tbl[i].edone = (i >= 16);
      end

      wdata[0] = '0;
      m_ready  = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("reset m_valid", 32'(m_valid), 32'd0);
      chk("reset m_data", 32'(m_data), 32'd0);
      chk("reset pixel_count", 32'(pixel_count), 32'd0);
      chk("reset frame_done", 32'(frame_done), 32'd0);
      chk("reset overflow", 32'(overflow), 32'd0);
      chk("reset excess", 32'(excess), 32'd0);
      rst_n = 1'b1;

      // Full frame with an always-ready sink, then excess beats.
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].wv, int'(tbl[i].data), tbl[i].rdy, 1'b0);
         chk($sformatf("v%0d m_valid", i), 32'(m_valid), 32'(tbl[i].ev));
         chk($sformatf("v%0d m_data", i), 32'(m_data), 32'(tbl[i].ed));
         chk($sformatf("v%0d m_last", i), 32'(m_last), 32'(tbl[i].el));
         chk($sformatf("v%0d pixel_count", i), 32'(pixel_count), 32'(tbl[i].epc));
         chk($sformatf("v%0d overflow", i), 32'(overflow), 32'(tbl[i].eovf));
         chk($sformatf("v%0d excess", i), 32'(excess), 32'(tbl[i].eexc));
         chk($sformatf("v%0d frame_done", i), 32'(frame_done), 32'(tbl[i].edone));
      end

      // Full FIFO with simultaneous push and pop.
      step(1'b0, 0, 1'b0, 1'b1);
      chk("flush frame_done", 32'(frame_done), 32'd0);
      chk("flush excess", 32'(excess), 32'd0);
      for (int i = 0; i < 8; i++) step(1'b1, i, 1'b0, 1'b0);
      chk("full overflow", 32'(overflow), 32'd0);
      chk("full pixel_count", 32'(pixel_count), 32'd8);
      step(1'b1, 8, 1'b1, 1'b0);
      chk("pushpop overflow", 32'(overflow), 32'd0);
      chk("pushpop pixel_count", 32'(pixel_count), 32'd9);
      drain_chk(1, 8);

      // Overflow: 10 beats into a depth-8 FIFO with a stalled sink.
      step(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, i, 1'b0, 1'b0);
      chk("ovf overflow", 32'(overflow), 32'd1);
      chk("ovf pixel_count", 32'(pixel_count), 32'd10);
      chk("ovf m_data", 32'(m_data), 32'd0);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("stall m_data stable", 32'(m_data), 32'd0);
      drain_chk(0, 8);

      // Mid-frame flush with three words buffered.
      step(1'b1, 20, 1'b1, 1'b0);
      step(1'b1, 21, 1'b1, 1'b0);
      step(1'b1, 22, 1'b1, 1'b0);
      step(1'b1, 23, 1'b0, 1'b0);
      step(1'b1, 24, 1'b0, 1'b0);
      chk("preflush pixel_count", 32'(pixel_count), 32'd15);
      chk("preflush m_data", 32'(m_data), 32'd22);
      step(1'b1, 99, 1'b1, 1'b1);
      chk("midflush m_valid", 32'(m_valid), 32'd0);
      chk("midflush pixel_count", 32'(pixel_count), 32'd0);
      chk("midflush overflow", 32'(overflow), 32'd0);
      chk("midflush excess", 32'(excess), 32'd0);
      chk("midflush frame_done", 32'(frame_done), 32'd0);
      step(1'b0, 0, 1'b1, 1'b0);
      chk("postflush m_valid", 32'(m_valid), 32'd0);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 100 + i, 1'b1, 1'b0);
         chk($sformatf("f2 beat%0d m_data", i), 32'(m_data), 32'(100 + i));
         chk($sformatf("f2 beat%0d m_last", i), 32'(m_last), 32'(i == 15));
      end
      step(1'b0, 0, 1'b1, 1'b0);
      chk("f2 frame_done", 32'(frame_done), 32'd1);
      chk("f2 pixel_count", 32'(pixel_count), 32'd16);
      chk("f2 m_valid", 32'(m_valid), 32'd0);

      // Asynchronous reset while draining.
      step(1'b0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) step(1'b1, i, 1'b0, 1'b0);
      step(1'b0, 0, 1'b0, 1'b0);
      chk("drain m_valid", 32'(m_valid), 32'd1);
      chk("drain frame_done", 32'(frame_done), 32'd0);
      chk("drain m_last dropped", 32'(m_last), 32'd0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async m_valid", 32'(m_valid), 32'd0);
      chk("async m_data", 32'(m_data), 32'd0);
      chk("async m_last", 32'(m_last), 32'd0);
      chk("async pixel_count", 32'(pixel_count), 32'd0);
      chk("async overflow", 32'(overflow), 32'd0);
      chk("async excess", 32'(excess), 32'd0);
      chk("async frame_done", 32'(frame_done), 32'd0);
`ifdef COLLECTOR_CHECKSUM_EN
      chk("async checksum", checksum, 32'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 5, 1'b1, 1'b0);
      chk("postrst m_data", 32'(m_data), 32'd5);
      chk("postrst pixel_count", 32'(pixel_count), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
